des_block_engine: RTL and testbench

//  Parametrised block sequencer for the iterative 16-round DES core.

---
 rtl/des_block_engine.sv | 166 ++++++++++++++++
 tb/tb_des_block_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_block_engine.sv
// Block sequencer for the iterative DES core: fetches 64-bit blocks from the input RAM,
// runs 16 rounds, applies ECB/CBC chaining and writes results to the output RAM.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; job parameters latched on accept
// S_LOAD   | fetch low/high words of block k (RD_LAT+2 cycles)
// S_ROUND  | des_round_sel sweeps 0..15; core result captured at 15
// S_SAVE_LO| write result low word to 2k
// S_SAVE_HI| write result high word to 2k+1
// S_NEXT   | count the block; loop to S_LOAD or finish
// S_DONE   | one-cycle done pulse
module des_block_engine #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              decrypt,
    input  logic              cbc,
    input  logic [63:0]       iv,
    input  logic [ADDR_W-2:0] block_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] blocks_done,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              out_we,
    output logic [3:0]        des_round_sel,
    output logic [63:0]       des_in,
    input  logic [63:0]       des_out,
    output logic              des_decrypt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ROUND, S_SAVE_LO, S_SAVE_HI, S_NEXT, S_DONE
    } state_t;

    localparam logic [1:0] LOAD_TC = 2'(RD_LAT + 1);

    state_t            state;
    logic [1:0]        load_cnt;
    logic              cbc_q;
    logic [ADDR_W-2:0] count_q;
    logic [63:0]       chain;
    logic [31:0]       x_lo;
    logic [63:0]       x_q;
    logic [31:0]       y_hi;
    logic              we_q;
    logic              done_q;

    logic [63:0]       x_full;
    logic [63:0]       y_full;
    logic [ADDR_W-2:0] bd_next;

    assign x_full  = {in_data, x_lo};
    assign y_full  = (cbc_q && des_decrypt) ? (des_out ^ chain) : des_out;
    assign bd_next = blocks_done + 1'b1;

    // abort and reset pre-empt a write or done pulse already registered for this cycle
    assign out_we = we_q & ~abort & ~reset;
    assign done   = done_q & ~abort & ~reset;

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            load_cnt      <= '0;
            cbc_q         <= 1'b0;
            count_q       <= '0;
            chain         <= '0;
            x_lo          <= '0;
            x_q           <= '0;
            y_hi          <= '0;
            we_q          <= 1'b0;
            done_q        <= 1'b0;
            busy          <= 1'b0;
            blocks_done   <= '0;
            in_addr       <= '0;
            out_addr      <= '0;
            out_data      <= '0;
            des_round_sel <= '0;
            des_in        <= '0;
            des_decrypt   <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            we_q          <= 1'b0;
            done_q        <= 1'b0;
            des_round_sel <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        des_decrypt <= decrypt;
                        cbc_q       <= cbc;
                        count_q     <= block_count;
                        chain       <= iv;
                        in_addr     <= '0;
                        out_addr    <= '0;
                        blocks_done <= '0;
                        load_cnt    <= LOAD_TC;
                        busy        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // load_cnt==1 lines up with word 2k arriving, ==0 with word 2k+1
                    if (load_cnt == LOAD_TC) in_addr <= {blocks_done, 1'b1};
                    if (load_cnt == 2'd1) x_lo <= in_data;
                    if (load_cnt == 2'd0) begin
                        x_q    <= x_full;
                        des_in <= (cbc_q && !des_decrypt) ? (x_full ^ chain) : x_full;
                        state  <= S_ROUND;
                    end else begin
                        load_cnt <= load_cnt - 1'b1;
                    end
                end
                S_ROUND: begin
                    if (des_round_sel == 4'd15) begin
                        des_round_sel <= '0;
                        out_addr      <= {blocks_done, 1'b0};
                        out_data      <= y_full[31:0];
                        y_hi          <= y_full[63:32];
                        we_q          <= 1'b1;
                        if (cbc_q) chain <= des_decrypt ? x_q : des_out;
                        state         <= S_SAVE_LO;
                    end else begin
                        des_round_sel <= des_round_sel + 1'b1;
                    end
                end
                S_SAVE_LO: begin
                    out_addr <= {blocks_done, 1'b1};
                    out_data <= y_hi;
                    state    <= S_SAVE_HI;
                end
                S_SAVE_HI: begin
                    we_q  <= 1'b0;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    blocks_done <= bd_next;
                    in_addr     <= {bd_next, 1'b0};
                    // count_q==0 means a full sweep: bd_next wraps to 0 on the last block
                    if (bd_next == count_q) begin
                        busy   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        load_cnt <= LOAD_TC;
                        state    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_block_engine.sv
// Bench for des_block_engine: a toy invertible cipher stands in for the DES core, and a
// per-cycle schedule model predicts every output from the job parameters and RAM contents.
module tb_des_block_engine;

    localparam int ADDR_W = 4;
    localparam int RD_LAT = 1;
    localparam int BW     = ADDR_W - 1;
    localparam int MW     = 1 << ADDR_W;
    localparam int NB     = 1 << BW;
    localparam int L      = RD_LAT + 2;
    localparam int BLK    = L + 19;
    localparam logic [63:0] KMASK = 64'hA5A5_A5A5_A5A5_A5A5;

    logic          ti_clk = 1'b0;
    logic          reset, start, abort, decrypt, cbc;
    logic [63:0]   iv;
    logic [BW-1:0] block_count;
    logic          busy, done, out_we, des_decrypt;
    logic [BW-1:0] blocks_done;
    logic [ADDR_W-1:0] in_addr, out_addr;
    logic [31:0]   in_data, out_data;
    logic [3:0]    des_round_sel;
    logic [63:0]   des_in, des_out;

    des_block_engine #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .ti_clk(ti_clk), .reset(reset), .start(start), .abort(abort),
        .decrypt(decrypt), .cbc(cbc), .iv(iv), .block_count(block_count),
        .busy(busy), .done(done), .blocks_done(blocks_done),
        .in_addr(in_addr), .in_data(in_data), .out_addr(out_addr),
        .out_data(out_data), .out_we(out_we), .des_round_sel(des_round_sel),
        .des_in(des_in), .des_out(des_out), .des_decrypt(des_decrypt)
    );

    always #5 ti_clk = ~ti_clk;

    function automatic logic [63:0] enc_f(input logic [63:0] x);
        return {x[55:0], x[63:56]} ^ KMASK;
    endfunction

    function automatic logic [63:0] dec_f(input logic [63:0] y);
        logic [63:0] t;
        t = y ^ KMASK;
        return {t[7:0], t[63:8]};
    endfunction

    // core stand-in: result only meaningful at round 15
    always_comb begin
        des_out = 64'hBAD0_BAD0_BAD0_BAD0;
        if (des_round_sel == 4'd15) des_out = des_decrypt ? dec_f(des_in) : enc_f(des_in);
    end

    logic [31:0] mem  [MW];
    logic [31:0] omem [MW];
    logic [31:0] rd_pipe [RD_LAT];
    logic        omem_clr = 1'b0;

    always @(posedge ti_clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem[in_addr];
    end
    assign in_data = rd_pipe[RD_LAT-1];

    always @(posedge ti_clk) begin
        if (omem_clr) begin
            for (int i = 0; i < MW; i++) omem[i] <= '1;
        end else if (out_we) begin
            omem[out_addr] <= out_data;
        end
    end

    int cyc = 0;
    always @(posedge ti_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // job descriptor read by the compare process
    logic [63:0] exp_din [NB];
    logic [63:0] exp_y   [NB];
    int  t0 = 0, jn = 0, stop = 0, rst_cyc = -1, bd_prev = 0;
    bit  job_on = 1'b0, jdec = 1'b0, post_reset = 1'b0, chk_en = 1'b0;

    int   m_rel, m_last, m_j, m_off, e_bd;
    logic e_busy, e_done, e_we, gated;

    always @(negedge ti_clk) begin
        if (chk_en) begin
            e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_bd = bd_prev;
            if (post_reset) begin
                chk("rst_ctrl", 64'({busy, done, out_we, des_decrypt, des_round_sel}), 64'd0);
                chk("rst_addr", 64'({blocks_done, in_addr, out_addr}), 64'd0);
                chk("rst_odata", 64'(out_data), 64'd0);
                chk("rst_din", des_in, 64'd0);
            end else begin
                if (job_on) begin
                    m_rel  = cyc - t0;
                    m_last = BLK * jn + 1;
                    if (m_rel >= 1 && m_rel <= m_last && m_rel <= stop) begin
                        gated = (m_rel == stop) || (cyc == rst_cyc);
                        if (m_rel < m_last) begin
                            m_j   = (m_rel - 1) / BLK;
                            m_off = (m_rel - 1) % BLK;
                            e_busy = 1'b1;
                            e_bd   = m_j;
                            e_we   = (m_off == L + 16 || m_off == L + 17) && !gated;
                            chk("in_addr", 64'(in_addr), 64'(((m_off == 0) ? 2*m_j : 2*m_j + 1) % MW));
                            chk("round_sel", 64'(des_round_sel),
                                64'((m_off >= L && m_off < L + 16) ? m_off - L : 0));
                            if (m_off >= L && m_off < L + 16) chk("des_in", des_in, exp_din[m_j]);
                            chk("des_decrypt", 64'(des_decrypt), 64'(jdec));
                            if (e_we) begin
                                chk("out_addr", 64'(out_addr),
                                    64'(((m_off == L + 16) ? 2*m_j : 2*m_j + 1) % MW));
                                chk("out_data", 64'(out_data),
                                    (m_off == L + 16) ? 64'(exp_y[m_j][31:0]) : 64'(exp_y[m_j][63:32]));
                            end
                        end else begin
                            e_done = !gated;
                            e_bd   = jn;
                            chk("end_addr", 64'(in_addr), 64'((2*jn) % MW));
                        end
                    end else if (m_rel > stop) begin
                        e_bd = (stop < m_last) ? (stop - 1) / BLK : jn;
                    end else if (m_rel > m_last) begin
                        e_bd = jn;
                    end
                end
                chk("busy", 64'(busy), 64'(e_busy));
                chk("done", 64'(done), 64'(e_done));
                chk("out_we", 64'(out_we), 64'(e_we));
                chk("blocks_done", 64'(blocks_done), 64'(e_bd % NB));
            end
        end
    end

    task automatic run_job(input int n, input bit dec, input bit cb, input logic [63:0] ivv,
                           input int abort_rel, input int start_rel, input int rst_rel);
        logic [63:0] ch, x, r;
        int end_rel;
        ch = ivv;
        for (int j = 0; j < n; j++) begin
            x = {mem[(2*j + 1) % MW], mem[(2*j) % MW]};
            if (cb && !dec) begin
                exp_din[j] = x ^ ch;
                exp_y[j]   = enc_f(x ^ ch);
                ch         = exp_y[j];
            end else begin
                exp_din[j] = x;
                r          = dec ? dec_f(x) : enc_f(x);
                exp_y[j]   = cb ? (r ^ ch) : r;
                ch         = x;
            end
        end
        @(posedge ti_clk); #1;
        start = 1'b1; decrypt = dec; cbc = cb; iv = ivv; block_count = BW'(n);
        t0 = cyc; jn = n; jdec = dec;
        stop = (abort_rel > 0) ? abort_rel : (1 << 30);
        rst_cyc = -1; post_reset = 1'b0; job_on = 1'b1;
        end_rel = ((stop < BLK*n + 1) ? stop : BLK*n + 1) + 1;
        for (int rel = 1; rel <= end_rel; rel++) begin
            @(posedge ti_clk); #1;
            start = 1'b0; abort = 1'b0;
            if (reset) begin
                reset = 1'b0; post_reset = 1'b1; bd_prev = 0; job_on = 1'b0;
                break;
            end
            start       = (rel == start_rel);
            abort       = (rel == abort_rel);
            decrypt     = 1'($urandom_range(0, 1));
            cbc         = 1'($urandom_range(0, 1));
            iv          = {$urandom, $urandom};
            block_count = BW'($urandom);
            if (rel == rst_rel) begin
                reset = 1'b1; rst_cyc = cyc;
            end
        end
        start = 1'b0; abort = 1'b0;
        if (reset) begin
            @(posedge ti_clk); #1;
            reset = 1'b0; post_reset = 1'b1; bd_prev = 0;
        end
        if (!post_reset) bd_prev = (stop < BLK*n + 1) ? (stop - 1) / BLK : n;
        job_on = 1'b0;
    endtask

    task automatic idle_poke();
        @(posedge ti_clk); #1;
        start = 1'b1; abort = 1'b1; decrypt = 1'b1; cbc = 1'b1;
        iv = {$urandom, $urandom}; block_count = BW'(3);
        @(posedge ti_clk); #1;
        start = 1'b0;
        @(posedge ti_clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge ti_clk);
    endtask

    task automatic clear_omem();
        @(posedge ti_clk); #1;
        omem_clr = 1'b1;
        @(posedge ti_clk); #1;
        omem_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; decrypt = 1'b0; cbc = 1'b0;
        iv = '0; block_count = '0;
        for (int i = 0; i < MW; i++) mem[i] = '0;
        @(posedge ti_clk); #1;
        post_reset = 1'b1; chk_en = 1'b1;
        repeat (2) @(posedge ti_clk);
        #1 reset = 1'b0;

        idle_poke();

        // single ECB encrypt, hand-derived result pins the model cipher
        mem[0] = 32'h89AB_CDEF; mem[1] = 32'h0123_4567;
        clear_omem();
        run_job(1, 1'b0, 1'b0, 64'd0, -1, -1, -1);
        chk("t1_lo", 64'(omem[0]), 64'h0E68_4AA4);
        chk("t1_hi", 64'(omem[1]), 64'h86E0_C22C);

        mem[0] = 32'h0E68_4AA4; mem[1] = 32'h86E0_C22C;
        clear_omem();
        run_job(1, 1'b1, 1'b0, 64'd0, -1, -1, -1);
        chk("t2_lo", 64'(omem[0]), 64'h89AB_CDEF);
        chk("t2_hi", 64'(omem[1]), 64'h0123_4567);
        chk("t2_bd", 64'(blocks_done), 64'd1);

        // CBC round trip over two blocks with a zero IV
        mem[0] = 32'h89AB_CDEF; mem[1] = 32'h0123_4567; mem[2] = '0; mem[3] = '0;
        clear_omem();
        run_job(2, 1'b0, 1'b1, 64'd0, -1, -1, -1);
        chk("t3_c1lo", 64'(omem[0]), 64'h0E68_4AA4);
        chk("t3_c1hi", 64'(omem[1]), 64'h86E0_C22C);
        chk("t3_c2lo", 64'(omem[2]), 64'hCDEF_0123);
        chk("t3_c2hi", 64'(omem[3]), 64'h4567_89AB);
        for (int i = 0; i < 4; i++) mem[i] = omem[i];
        clear_omem();
        run_job(2, 1'b1, 1'b1, 64'd0, -1, -1, -1);
        chk("t3_p1lo", 64'(omem[0]), 64'h89AB_CDEF);
        chk("t3_p1hi", 64'(omem[1]), 64'h0123_4567);
        chk("t3_p2lo", 64'(omem[2]), 64'd0);
        chk("t3_p2hi", 64'(omem[3]), 64'd0);

        // full sweep with block_count=0
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        run_job(NB, 1'b0, 1'b1, {$urandom, $urandom}, -1, -1, -1);
        chk("t4_bd", 64'(blocks_done), 64'd0);
        chk("t4_addr", 64'(in_addr), 64'd0);

        // abort in ROUND of the third of five blocks
        run_job(5, 1'b0, 1'b0, 64'd0, 1 + 2*BLK + L + 5, -1, -1);
        chk("t5_bd", 64'(blocks_done), 64'd2);
        chk("t5_busy", 64'(busy), 64'd0);

        // start mid-job, then reset during SAVE_HI of block 2
        run_job(3, 1'b1, 1'b1, {$urandom, $urandom}, -1, 10, 1 + BLK + L + 17);
        chk("t6_bd", 64'(blocks_done), 64'd0);
        idle_poke();

        for (int k = 0; k < 24; k++) begin
            int n, ab, st, rs;
            for (int i = 0; i < MW; i++) mem[i] = $urandom;
            n  = $urandom_range(1, NB);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BLK*n + 1) : -1;
            st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, BLK*n) : -1;
            rs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, BLK*n) : -1;
            run_job(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, ab, st, rs);
            repeat ($urandom_range(0, 3)) @(posedge ti_clk);
        end

        repeat (3) @(posedge ti_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
